// File: rtl/pkt_rr_scheduler.sv
// Packet-locked round-robin arbiter with per-source quantum; zero-cycle grant of first beat.
// Backpressure: only the granted source sees i_ready on o_ready_vec; others are held off.
module pkt_rr_scheduler #(
  parameter int PORTS   = 4,
  parameter int DATA_W  = 32,
  parameter int QUANTUM = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic [PORTS-1:0]           i_valid_vec,
  input  logic [PORTS-1:0]           i_last_vec,
  input  logic [PORTS*DATA_W-1:0]    i_data,
  output logic [PORTS-1:0]           o_ready_vec,
  output logic [PORTS-1:0]           o_grant_vec,
  output logic                       o_valid,
  output logic                       o_last,
  output logic [DATA_W-1:0]          o_data,
  output logic [$clog2(PORTS)-1:0]   o_src,
  input  logic                       i_ready
);

  localparam int SRC_W = $clog2(PORTS);
  localparam int CNT_W = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            r_state;
  logic [SRC_W-1:0]  r_owner;
  logic [SRC_W-1:0]  r_ptr;
  logic [CNT_W-1:0]  r_cnt;

  logic [DATA_W-1:0] w_dat_arr [PORTS];
  logic              w_found;
  logic [SRC_W-1:0]  w_win;
  logic [SRC_W-1:0]  w_idx;
  logic [SRC_W-1:0]  w_sel;
  logic              w_req;
  logic              w_vld;
  logic              w_last;
  logic              w_xfer;
  logic [CNT_W-1:0]  w_base;
  logic [CNT_W:0]    w_n;
  logic              w_wrap;
  logic [SRC_W-1:0]  w_next_ptr;

  for (genvar k = 0; k < PORTS; k++) begin : g_port
    assign w_dat_arr[k] = i_data[k*DATA_W +: DATA_W];
  end

  // Walk PORTS positions from r_ptr with explicit wrap so non-power-of-2 PORTS works.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = r_ptr;
    for (int i = 0; i < PORTS; i++) begin
      if (!w_found && i_valid_vec[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
      w_idx = (w_idx == SRC_W'(PORTS-1)) ? '0 : w_idx + SRC_W'(1);
    end
  end

  assign w_sel      = (r_state == BUSY) ? r_owner : w_win;
  assign w_req      = (r_state == BUSY) ? 1'b1 : w_found;
  assign w_vld      = w_req & i_valid_vec[w_sel];
  assign w_last     = i_last_vec[w_sel];
  assign w_xfer     = i_rstn & w_vld & i_ready;
  // A new tenure starts from zero when someone other than the previous owner wins.
  assign w_base     = (r_state == IDLE && w_win != r_owner) ? '0 : r_cnt;
  assign w_n        = {1'b0, w_base} + (CNT_W+1)'(1);
  assign w_wrap     = (w_n == (CNT_W+1)'(QUANTUM));
  assign w_next_ptr = (w_sel == SRC_W'(PORTS-1)) ? '0 : w_sel + SRC_W'(1);

  always_comb begin
    o_grant_vec = '0;
    o_ready_vec = '0;
    o_valid     = 1'b0;
    o_last      = 1'b0;
    o_data      = '0;
    o_src       = '0;
    if (i_rstn && w_req) begin
      o_grant_vec = PORTS'(1) << w_sel;
      o_ready_vec = o_grant_vec & {PORTS{i_ready}};
      o_valid     = w_vld;
      o_src       = w_sel;
      if (w_vld) begin
        o_data = w_dat_arr[w_sel];
        o_last = w_last;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else if (w_xfer) begin
      r_owner <= w_sel;
      if (w_last) begin
        r_state <= IDLE;
        if (w_wrap) begin
          r_ptr <= w_next_ptr;
          r_cnt <= '0;
        end else begin
          r_ptr <= w_sel;
          r_cnt <= w_n[CNT_W-1:0];
        end
      end else begin
        r_state <= BUSY;
        r_cnt   <= w_base;
      end
    end
  end

endmodule

// File: tb/tb_pkt_rr_scheduler.sv
// Randomized scoreboard bench for pkt_rr_scheduler plus directed checks on a 3-port, quantum-1 instance.
// Expected beats come from a packet-level arbitration model; a monitor pops them on each DUT handshake.
module tb_pkt_rr_scheduler;
  localparam int P = 4;
  localparam int W = 32;
  localparam int Q = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rstn;
  logic [P-1:0]   vld, lst;
  logic [P*W-1:0] dat;
  logic           rdy;
  logic [P-1:0]   o_ready_vec, o_grant_vec;
  logic           o_valid, o_last;
  logic [W-1:0]   o_data;
  logic [1:0]     o_src;

  pkt_rr_scheduler #(.PORTS(P), .DATA_W(W), .QUANTUM(Q)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_valid_vec(vld), .i_last_vec(lst), .i_data(dat),
    .o_ready_vec(o_ready_vec), .o_grant_vec(o_grant_vec), .o_valid(o_valid),
    .o_last(o_last), .o_data(o_data), .o_src(o_src), .i_ready(rdy)
  );

  logic [2:0]  v3, l3, r3, g3;
  logic [95:0] d3;
  logic        rdy3, ov3, ol3;
  logic [31:0] od3;
  logic [1:0]  os3;

  pkt_rr_scheduler #(.PORTS(3), .DATA_W(32), .QUANTUM(1)) dut3 (
    .i_clk(clk), .i_rstn(rstn), .i_valid_vec(v3), .i_last_vec(l3), .i_data(d3),
    .o_ready_vec(r3), .o_grant_vec(g3), .o_valid(ov3),
    .o_last(ol3), .o_data(od3), .o_src(os3), .i_ready(rdy3)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Source generators: packets obey the stream rule (held until accepted).
  int          rem [P];
  int          seq [P];
  bit          pres[P];
  logic [P-1:0] mask;
  int p_new, p_pres, p_drop, p_rdy, minlen, maxlen;

  task automatic knobs(input logic [P-1:0] m, input int mn, input int mx, input int pn,
                       input int pp, input int pd, input int pr);
    mask = m; minlen = mn; maxlen = mx; p_new = pn; p_pres = pp; p_drop = pd; p_rdy = pr;
  endtask

  task automatic gen(input logic [P-1:0] acc);
    for (int k = 0; k < P; k++) begin
      if (acc[k]) begin
        rem[k]--;
        seq[k]++;
        if (int'($urandom_range(0, 99)) < p_drop) pres[k] = 1'b0;
      end
      if (rem[k] == 0) begin
        pres[k] = 1'b0;
        if (mask[k] && int'($urandom_range(0, 99)) < p_new)
          rem[k] = int'($urandom_range(minlen, maxlen));
      end
      if (rem[k] > 0 && !pres[k] && int'($urandom_range(0, 99)) < p_pres) pres[k] = 1'b1;
      vld[k] = pres[k];
      lst[k] = (rem[k] == 1);
      dat[k*W +: W] = {8'(k), 24'(seq[k])};
    end
    rdy = (int'($urandom_range(0, 99)) < p_rdy);
  endtask

  task automatic step();
    logic [P-1:0] acc;
    @(negedge clk);
    acc = o_ready_vec & vld;
    @(posedge clk);
    #1;
    gen(acc);
  endtask

  task automatic release_rst();
    rstn = 1'b1;
    for (int k = 0; k < P; k++) begin
      rem[k] = 0;
      pres[k] = 1'b0;
    end
    gen('0);
  endtask

  // Reference model: packet-level view of who may send next.
  typedef struct { logic [P-1:0] grant; logic v; logic zero; } gexp_t;
  typedef struct { int src; logic [W-1:0] d; logic l; } beat_t;
  gexp_t gq[$];
  beat_t bq[$];
  int    xlog[$];
  int m_start = 0, m_holder = 0, m_run = 0;
  bit m_lock = 1'b0;

  always @(negedge clk) begin : model
    gexp_t e;
    beat_t b;
    int sel;
    e.grant = '0; e.v = 1'b0; e.zero = 1'b1; sel = -1;
    if (!rstn) begin
      m_start = 0; m_holder = 0; m_run = 0; m_lock = 1'b0;
    end else begin
      if (m_lock) sel = m_holder;
      else
        for (int i = 0; i < P; i++)
          if (sel < 0 && vld[(m_start + i) % P]) sel = (m_start + i) % P;
      if (sel >= 0) begin
        e.grant = P'(1) << sel;
        e.v = vld[sel];
        e.zero = 1'b0;
      end
      if (e.v && rdy) begin
        b.src = sel; b.d = dat[sel*W +: W]; b.l = lst[sel];
        bq.push_back(b);
        if (!m_lock && sel != m_holder) m_run = 0;
        m_holder = sel;
        m_lock = 1'b1;
        if (lst[sel]) begin
          m_lock = 1'b0;
          m_run++;
          if (m_run == Q) begin
            m_run = 0;
            m_start = (sel + 1) % P;
          end else begin
            m_start = sel;
          end
        end
      end
    end
    gq.push_back(e);
  end

  always @(negedge clk) begin : monitor
    gexp_t e;
    beat_t b;
    #1;
    if (gq.size() > 0) begin
      e = gq.pop_front();
      chk("grant", o_grant_vec, e.grant);
      chk("valid", o_valid, e.v);
      chk("ready_vec", o_ready_vec, e.grant & {P{rdy & rstn}});
      if (e.zero) chk("zero_out", {o_data, o_last, o_src}, '0);
      if (o_valid && rdy && rstn) begin
        xlog.push_back(int'(o_src));
        if (bq.size() == 0) chk("beat_q_level", bq.size(), 1);
        else begin
          b = bq.pop_front();
          chk("beat_src", o_src, b.src);
          chk("beat_data", o_data, b.d);
          chk("beat_last", o_last, b.l);
        end
      end
    end
  end

  initial begin
    int exp1 [5] = '{1, 1, 3, 3, 1};
    rstn = 1'b0; vld = '0; lst = '0; dat = '0; rdy = 1'b0;
    v3 = '0; l3 = '0; d3 = {32'd102, 32'd101, 32'd100}; rdy3 = 1'b0;
    for (int k = 0; k < P; k++) begin
      rem[k] = 0; seq[k] = 0; pres[k] = 1'b0;
    end
    knobs('0, 1, 1, 0, 0, 0, 0);
    repeat (3) step();

    // Two always-valid sources with single-beat packets: quantum 2 alternation, no gaps.
    knobs(4'b1010, 1, 1, 100, 100, 0, 100);
    xlog.delete();
    release_rst();
    repeat (12) step();
    chk("p1_count", xlog.size(), 12);
    for (int i = 0; i < 5; i++)
      if (i < xlog.size()) chk("p1_seq", xlog[i], exp1[i]);

    // Random multi-beat packets with bubbles and sink backpressure.
    rstn = 1'b0;
    repeat (2) step();
    knobs(4'b1111, 1, 4, 60, 70, 25, 70);
    release_rst();
    repeat (1500) step();

    // Short packets with shifting requester sets to exercise fresh tenure counts.
    knobs(4'b1111, 1, 2, 90, 90, 10, 90);
    for (int j = 0; j < 12; j++) begin
      mask = 4'($urandom_range(1, 15));
      repeat (40) step();
    end

    // Reset during beat 2 of a 3-beat packet from src3.
    rstn = 1'b0;
    repeat (2) step();
    knobs(4'b1000, 3, 3, 100, 100, 0, 100);
    release_rst();
    for (int i = 0; i < 20 && !(rem[3] == 2 && pres[3]); i++) step();
    chk("p3_beat2", rem[3], 2);
    rstn = 1'b0;
    knobs(4'b1010, 1, 1, 100, 100, 0, 100);
    repeat (3) step();
    xlog.delete();
    release_rst();
    repeat (4) step();
    chk("p3_first_after_rst", (xlog.size() > 0) ? xlog[0] : -1, 1);

    // Three ports, quantum 1: pure round robin wrapping 2 -> 0.
    rstn = 1'b0;
    knobs('0, 1, 1, 0, 0, 0, 100);
    repeat (2) step();
    release_rst();
    v3 = 3'b111; l3 = 3'b111; rdy3 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      chk("p4_src", os3, i % 3);
      chk("p4_grant", g3, 3'b001 << (i % 3));
      chk("p4_data", od3, 100 + (i % 3));
      chk("p4_valid", ov3, 1);
    end
    v3 = '0;
    repeat (2) step();
    chk("beats_drained", bq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
